seq_player: RTL and testbench

- Upstream stage of the Simon Says comparator.
- Holds the growing random sequence of colour steps and plays the current round on the LEDs.
- During the player-input phase it presents the expected step as a one-hot `actual` with an `on_off` enable, which the comparator checks against the switches.
- Advances one step per player press; the game controller drives rounds via start/next_round.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/lfsr8.sv | 24 ++
 rtl/seq_player.sv | 158 +++++++++++++++
 tb/tb_seq_player.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says pipeline stages.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        SHOW_ON,
        SHOW_OFF,
        INPUT
    } seq_state_t;

    typedef logic [1:0] step_code_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] onehot4(step_code_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; advances every clock while out of reset.
module lfsr8
    import simon_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= SEED;
        end else begin
            q_reg <= {q_reg[6:0], ^(q_reg & LFSR_TAPS)};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/seq_player.sv
// Stores the random colour sequence, plays it back on the LEDs and then
// presents each expected step to the comparator while the player answers.
module seq_player
    import simon_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter int         SHOW_CYCLES = 25_000_000,
    parameter int         GAP_CYCLES  = 12_500_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       next_round,
    input  logic       step_done,
    output logic [3:0] leds,
    output logic [3:0] actual,
    output logic       on_off,
    output logic [4:0] round_len,
    output logic       busy,
    output logic       seq_end,
    output logic       full
);

    localparam int PTR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W   = PTR_W + 1;
    localparam int TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

    seq_state_t        state_reg, state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [TMR_W-1:0]  timer_reg, timer_next;
    logic              seq_end_reg, seq_end_next;
    logic              mem_we;
    logic              last_step;
    logic [7:0]        lfsr_q;
    logic              unused_lfsr_bits;
    step_code_t        cur_code;

    // Sequence is tiny, so an asynchronously read array keeps the LED and
    // actual outputs aligned with ptr without an extra pipeline stage.
    step_code_t        mem [MAX_LEN];

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[7:2];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len_reg[PTR_W-1:0]] <= lfsr_q[1:0];
        end
    end

    assign cur_code  = mem[ptr_reg];
    assign last_step = ({1'b0, ptr_reg} == (len_reg - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            ptr_reg     <= '0;
            timer_reg   <= '0;
            seq_end_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            ptr_reg     <= ptr_next;
            timer_reg   <= timer_next;
            seq_end_reg <= seq_end_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        ptr_next     = ptr_reg;
        timer_next   = timer_reg;
        seq_end_next = 1'b0;
        mem_we       = 1'b0;

        if (start) begin
            len_next   = '0;
            state_next = APPEND;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (next_round && (len_reg != '0)) begin
                        state_next = APPEND;
                    end
                end
                APPEND: begin
                    // Once full the round is simply replayed unchanged
                    if (len_reg < MAX_LEN_L) begin
                        mem_we   = 1'b1;
                        len_next = len_reg + LEN_W'(1);
                    end
                    ptr_next   = '0;
                    timer_next = '0;
                    state_next = SHOW_ON;
                end
                SHOW_ON: begin
                    if (timer_reg == SHOW_LAST) begin
                        timer_next = '0;
                        state_next = SHOW_OFF;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
                SHOW_OFF: begin
                    if (timer_reg == GAP_LAST) begin
                        timer_next = '0;
                        if (last_step) begin
                            ptr_next   = '0;
                            state_next = INPUT;
                        end else begin
                            ptr_next   = ptr_reg + PTR_W'(1);
                            state_next = SHOW_ON;
                        end
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
                INPUT: begin
                    if (step_done) begin
                        if (last_step) begin
                            seq_end_next = 1'b1;
                            ptr_next     = '0;
                            state_next   = IDLE;
                        end else begin
                            ptr_next = ptr_reg + PTR_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign on_off    = (state_reg == INPUT);
    assign leds      = (state_reg == SHOW_ON) ? onehot4(cur_code) : 4'b0000;
    assign actual    = on_off ? onehot4(cur_code) : 4'b0000;
    assign busy      = (state_reg == APPEND) || (state_reg == SHOW_ON) || (state_reg == SHOW_OFF);
    assign seq_end   = seq_end_reg;
    assign full      = (len_reg == MAX_LEN_L);
    assign round_len = 5'(len_reg);

endmodule

// File: tb/tb_seq_player.sv
// Randomised bench for seq_player: a queue of expected step codes drawn from a
// reference LFSR drives the expected playback and input-phase behaviour.
module tb_seq_player;

    localparam int         MAX_LEN = 4;
    localparam int         SHOW    = 4;
    localparam int         GAP     = 2;
    localparam logic [7:0] SEED    = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       next_round = 1'b0;
    logic       step_done = 1'b0;
    logic [3:0] leds;
    logic [3:0] actual;
    logic       on_off;
    logic [4:0] round_len;
    logic       busy;
    logic       seq_end;
    logic       full;

    int         total = 0;
    int         bad = 0;
    logic [7:0] model_lfsr;
    logic [1:0] exp_q[$];

    seq_player #(
        .MAX_LEN     (MAX_LEN),
        .SHOW_CYCLES (SHOW),
        .GAP_CYCLES  (GAP),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .next_round (next_round),
        .step_done  (step_done),
        .leds       (leds),
        .actual     (actual),
        .on_off     (on_off),
        .round_len  (round_len),
        .busy       (busy),
        .seq_end    (seq_end),
        .full       (full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] r;
        r = 4'b0000;
        r[c] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        model_lfsr <= reset ? SEED : lfsr_step(model_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic chk_idle();
        chk("idle_leds", 32'(leds), 0);
        chk("idle_actual", 32'(actual), 0);
        chk("idle_on_off", 32'(on_off), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_seq_end", 32'(seq_end), 0);
        chk("idle_len", 32'(round_len), exp_q.size());
    endtask

    // Pulse start/next_round at the current falling edge, land in APPEND
    task automatic launch(input bit new_game, input bit with_step);
        if (new_game) start = 1'b1;
        else next_round = 1'b1;
        step_done = with_step;
        @(negedge clk);
        start = 1'b0;
        next_round = 1'b0;
        step_done = 1'b0;
        chk("append_busy", 32'(busy), 1);
        chk("append_seq_end", 32'(seq_end), 0);
        chk("append_on_off", 32'(on_off), 0);
        if (new_game) exp_q.delete();
        chk("append_len", 32'(round_len), exp_q.size());
        if (exp_q.size() < MAX_LEN) exp_q.push_back(model_lfsr[1:0]);
    endtask

    // Follow playback cycle by cycle; abort_at >= 0 returns early mid-playback
    task automatic playback(input int abort_at);
        int n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int c = 0; c < SHOW; c++) begin
                @(negedge clk);
                chk("show_leds", 32'(leds), 32'(oh(exp_q[i])));
                chk("show_busy", 32'(busy), 1);
                if (n == 0) begin
                    chk("show_len", 32'(round_len), exp_q.size());
                    chk("show_full", 32'(full), 32'(exp_q.size() == MAX_LEN));
                end
                if (n == abort_at) begin
                    $display("playback aborted at cycle %0d len=%0d", n, exp_q.size());
                    return;
                end
                n++;
            end
            for (int c = 0; c < GAP; c++) begin
                @(negedge clk);
                chk("gap_leds", 32'(leds), 0);
                chk("gap_busy", 32'(busy), 1);
                n++;
            end
        end
        @(negedge clk);
        chk("input_on_off", 32'(on_off), 1);
        chk("input_busy", 32'(busy), 0);
        chk("input_leds", 32'(leds), 0);
        chk("input_actual0", 32'(actual), 32'(oh(exp_q[0])));
        $display("playback done len=%0d full=%0b", exp_q.size(), full);
    endtask

    // Answer every step with random think time; optionally restart on the last one
    task automatic play_input(input bit abort_last);
        int len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            int d = $urandom_range(0, 2);
            repeat (d) begin
                next_round = 1'($urandom_range(0, 1));
                @(negedge clk);
                next_round = 1'b0;
                chk("wait_actual", 32'(actual), 32'(oh(exp_q[i])));
                chk("wait_on_off", 32'(on_off), 1);
            end
            if (i == len - 1 && abort_last) begin
                launch(1'b1, 1'b1);
                $display("input restarted on last step len=%0d", len);
                return;
            end
            step_done = 1'b1;
            @(negedge clk);
            step_done = 1'b0;
            if (i == len - 1) begin
                chk("last_seq_end", 32'(seq_end), 1);
                chk("last_on_off", 32'(on_off), 0);
                chk("last_busy", 32'(busy), 0);
                chk("last_actual", 32'(actual), 0);
                chk("last_len", 32'(round_len), len);
                @(negedge clk);
                chk("seq_end_pulse", 32'(seq_end), 0);
            end else begin
                chk("step_seq_end", 32'(seq_end), 0);
                chk("step_actual", 32'(actual), 32'(oh(exp_q[i + 1])));
            end
        end
        $display("input done len=%0d", len);
    endtask

    // IDLE dwell with stray step_done pulses that must be ignored
    task automatic idle_gap();
        int d = $urandom_range(0, 3);
        repeat (d) begin
            step_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            step_done = 1'b0;
            chk_idle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle();
        reset = 1'b0;
        @(negedge clk);
        chk_idle();
        chk("reset_full", 32'(full), 0);
        step_done = 1'b1;
        @(negedge clk);
        step_done = 1'b0;
        chk_idle();
        next_round = 1'b1;
        @(negedge clk);
        next_round = 1'b0;
        chk_idle();
        @(negedge clk);
        chk_idle();
        $display("reset and idle checks done");

        // Game 1: grow to full, then replay once without growth
        launch(1'b1, 1'b0);
        playback(-1);
        play_input(1'b0);
        for (int r = 2; r <= MAX_LEN + 1; r++) begin
            idle_gap();
            launch(1'b0, 1'b0);
            playback(-1);
            play_input(1'b0);
        end

        // Game 2: abort round 3 mid-show, then restart on the final answer
        idle_gap();
        launch(1'b1, 1'b0);
        playback(-1);
        play_input(1'b0);
        for (int r = 2; r <= 3; r++) begin
            idle_gap();
            launch(1'b0, 1'b0);
            playback(r == 3 ? 2 : -1);
            if (r != 3) play_input(1'b0);
        end
        launch(1'b1, 1'b0);
        playback(-1);
        play_input(1'b0);
        idle_gap();
        launch(1'b0, 1'b0);
        playback(-1);
        play_input(1'b1);
        playback(-1);
        play_input(1'b0);

        // A few more random-length games
        for (int g = 0; g < 3; g++) begin
            int rounds = $urandom_range(1, MAX_LEN + 1);
            idle_gap();
            launch(1'b1, 1'b0);
            playback(-1);
            play_input(1'b0);
            for (int r = 2; r <= rounds; r++) begin
                idle_gap();
                launch(1'b0, 1'b0);
                playback(-1);
                play_input(1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
